// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART-side bundle for uart_tx_arbiter.
// slave = arbiter side, master = requesters plus UART side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   req_grant;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_start;
  logic                 uart_tx_ready;
  logic                 busy;
  logic                 err_timeout;

  modport master (
    output req_valid,
    output req_data,
    output uart_tx_ready,
    input  req_ack,
    input  req_grant,
    input  uart_tx_data,
    input  uart_tx_start,
    input  busy,
    input  err_timeout
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  uart_tx_ready,
    output req_ack,
    output req_grant,
    output uart_tx_data,
    output uart_tx_start,
    output busy,
    output err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter.
// Ports: clk, rst_n (async low), bus (uart_tx_arbiter_if.slave):
//   req_valid/req_data/req_ack/req_grant per source, uart_tx_data,
//   uart_tx_start, uart_tx_ready, busy, err_timeout.
// Optional: `define UART_TX_ARB_TIMEOUT_EN for the tx_ready timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      cur;
  logic [PW-1:0]      sel;
  logic [PW-1:0]      cand;
  logic               found;
  int                 idx;
  logic [NUM_REQ-1:0] vmask;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         data_q;
  logic               start_q;
  logic               err_q;
  logic [GW-1:0]      gap_cnt;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`endif

  // A source being acked this cycle is masked so a held
  // req_valid cannot win a second grant in its own ack cycle.
  always_comb begin
    vmask = bus.req_valid & ~ack_q;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!found && vmask[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= PW'(NUM_REQ - 1);
      cur     <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      gap_cnt <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q   <= '0;
      start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found && bus.uart_tx_ready) begin
            cur     <= sel;
            data_q  <= bus.req_data[{sel, 3'b000} +: 8];
            grant_q <= NUM_REQ'(1) << sel;
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.uart_tx_ready) begin
            state <= WAIT_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          // UART never took the frame: drop it, keep rr_ptr
          // so the same source is first in line again.
          else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (bus.uart_tx_ready) begin
            ack_q   <= NUM_REQ'(1) << cur;
            grant_q <= '0;
            rr_ptr  <= cur;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GW'(GAP_LOAD);
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_TX_ARB_TIMEOUT_EN
  // Always 0 for any legal BUSY_TIMEOUT.
  assign err_q = (BUSY_TIMEOUT < 0);
`endif

  assign bus.req_ack       = ack_q;
  assign bus.req_grant     = grant_q;
  assign bus.uart_tx_data  = data_q;
  assign bus.uart_tx_start = start_q;
  assign bus.busy          = (state != IDLE);
  assign bus.err_timeout   = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench for uart_tx_arbiter with a
// round-robin reference model and a reactive UART model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 5;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .GAP_CYCLES(GAP),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [N-1:0] valid = '0;
  logic [7:0]   db [N];
  logic         uart_auto = 1'b1;
  logic         ready_man = 1'b1;
  logic         ready_auto;
  int           drop_dly = 2;
  int           frame_len = 8;
  int           errs = 0;
  int           checks = 0;
  int           rr_last = N - 1;

  assign bus.req_valid = valid;
  assign bus.req_data  = {db[3], db[2], db[1], db[0]};
  assign bus.uart_tx_ready = uart_auto ? ready_auto : ready_man;

  // UART: drop ready drop_dly cycles after start, hold frame_len.
  initial begin
    ready_auto = 1'b1;
    forever begin
      @(negedge clk);
      if (uart_auto && bus.uart_tx_start === 1'b1) begin
        repeat (drop_dly) @(negedge clk);
        ready_auto = 1'b0;
        repeat (frame_len) @(negedge clk);
        ready_auto = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (((v >> j) & N'(1)) != '0) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_last = N - 1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.uart_tx_ready === 1'b1) return;
    end
    checks++; errs++;
    $display("FAIL wait_idle: busy=%b ready=%b want 0/1",
             bus.busy, bus.uart_tx_ready);
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.uart_tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errs++;
      $display("FAIL wait_start: none in %0d cycles", budget);
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.req_ack !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errs++;
      $display("FAIL wait_ack: none in %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    valid = '1;
    @(negedge clk);
    checks++;
    if (bus.req_grant !== '0) begin
      errs++; $display("FAIL reset_grant: got %b want 0", bus.req_grant);
    end
    checks++;
    if (bus.req_ack !== '0) begin
      errs++; $display("FAIL reset_ack: got %b want 0", bus.req_ack);
    end
    checks++;
    if (bus.uart_tx_start !== 1'b0) begin
      errs++; $display("FAIL reset_start: got %b want 0", bus.uart_tx_start);
    end
    checks++;
    if (bus.uart_tx_data !== 8'h00) begin
      errs++; $display("FAIL reset_data: got %h want 00", bus.uart_tx_data);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errs++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.err_timeout !== 1'b0) begin
      errs++; $display("FAIL reset_err: got %b want 0", bus.err_timeout);
    end
    valid = '0;
    rst_n = 1'b1;
    rr_last = N - 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int starts, acks, gcyc, bad, first, e;
    logic [N-1:0] ackv, oh;
    uart_auto = 1'b1;
    drop_dly = 2;
    frame_len = 100;
    foreach (db[i]) db[i] = 8'($urandom);
    db[2] = 8'hA5;
    valid = 4'b0100;
    e = rr_pick(valid, rr_last);
    oh = N'(1) << e;
    starts = 0; acks = 0; gcyc = 0; bad = 0; first = -1; ackv = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.uart_tx_start === 1'b1) begin
        starts++;
        if (first < 0) first = c;
        checks++;
        if (bus.uart_tx_data !== db[e]) begin
          errs++;
          $display("FAIL single_data: got %h want %h", bus.uart_tx_data, db[e]);
        end
      end
      if (bus.req_ack !== '0) begin
        acks++;
        ackv = bus.req_ack;
        valid = '0;
      end
      if (bus.req_grant === oh) gcyc++;
      else if (bus.req_grant !== '0) bad++;
    end
    checks++;
    if (starts != 1) begin
      errs++; $display("FAIL single_starts: got %0d want 1", starts);
    end
    checks++;
    if (first != 0) begin
      errs++; $display("FAIL single_latency: got %0d want 0", first);
    end
    checks++;
    if (acks != 1 || ackv !== oh) begin
      errs++; $display("FAIL single_ack: got %0d x %b want 1 x %b", acks, ackv, oh);
    end
    checks++;
    if (gcyc != 1 + drop_dly + frame_len || bad != 0) begin
      errs++;
      $display("FAIL single_grant: got %0d cycles (%0d bad) want %0d",
               gcyc, bad, 1 + drop_dly + frame_len);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errs++; $display("FAIL single_busy: got %b want 0", bus.busy);
    end
    rr_last = e;
  endtask

  task automatic test_round_robin();
    bit ok;
    int e;
    logic [N-1:0] oh;
    do_reset();
    uart_auto = 1'b1;
    foreach (db[i]) db[i] = 8'($urandom);
    valid = '1;
    for (int f = 0; f < 8; f++) begin
      drop_dly = $urandom_range(1, 3);
      frame_len = $urandom_range(2, 10);
      e = rr_pick(valid, rr_last);
      oh = N'(1) << e;
      wait_start(100, ok);
      if (!ok) return;
      checks++;
      if (bus.req_grant !== oh) begin
        errs++; $display("FAIL rr_grant f%0d: got %b want %b", f, bus.req_grant, oh);
      end
      checks++;
      if (bus.uart_tx_data !== db[e]) begin
        errs++; $display("FAIL rr_data f%0d: got %h want %h", f, bus.uart_tx_data, db[e]);
      end
      wait_ack(100, ok);
      if (!ok) return;
      checks++;
      if (bus.req_ack !== oh || bus.req_grant !== '0) begin
        errs++;
        $display("FAIL rr_ack f%0d: got ack %b grant %b want %b/0",
                 f, bus.req_ack, bus.req_grant, oh);
      end
      @(negedge clk);
      checks++;
      if (bus.req_ack !== '0) begin
        errs++; $display("FAIL rr_ack_width f%0d: got %b want 0", f, bus.req_ack);
      end
      rr_last = e;
      db[e] = 8'($urandom);
    end
    valid = '0;
  endtask

  task automatic test_gap();
    bit ok;
    int a, b, e1, e2, n, idle, gbad;
    wait_idle();
    uart_auto = 1'b1;
    drop_dly = 1;
    frame_len = 4;
    a = $urandom_range(0, 3);
    b = (a + $urandom_range(1, 3)) % N;
    valid = (N'(1) << a) | (N'(1) << b);
    e1 = rr_pick(valid, rr_last);
    wait_start(20, ok);
    wait_ack(50, ok);
    checks++;
    if (bus.req_ack !== N'(1) << e1) begin
      errs++; $display("FAIL gap_ack1: got %b want %b", bus.req_ack, N'(1) << e1);
    end
    valid = valid & ~(N'(1) << e1);
    rr_last = e1;
    e2 = rr_pick(valid, rr_last);
    n = 0; idle = 0; gbad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n++;
      if (bus.uart_tx_start === 1'b1) break;
      if (bus.busy === 1'b0) idle++;
      if (bus.req_grant !== '0) gbad++;
    end
    checks++;
    if (n - 1 != GAP) begin
      errs++; $display("FAIL gap_len: got %0d idle cycles want %0d", n - 1, GAP);
    end
    checks++;
    if (idle != 1 || gbad != 0) begin
      errs++; $display("FAIL gap_idle: got %0d idle, %0d grants want 1, 0", idle, gbad);
    end
    checks++;
    if (bus.req_grant !== N'(1) << e2) begin
      errs++; $display("FAIL gap_grant2: got %b want %b", bus.req_grant, N'(1) << e2);
    end
    wait_ack(50, ok);
    valid = '0;
    rr_last = e2;
  endtask

  task automatic test_not_ready();
    bit ok;
    int e, bad;
    wait_idle();
    ready_man = 1'b0;
    uart_auto = 1'b0;
    valid = N'(1) << $urandom_range(0, 3);
    e = rr_pick(valid, rr_last);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_grant !== '0 || bus.uart_tx_start !== 1'b0 ||
          bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++; $display("FAIL nr_hold: got %0d active cycles want 0", bad);
    end
    ready_man = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_grant !== N'(1) << e || bus.uart_tx_start !== 1'b1) begin
      errs++;
      $display("FAIL nr_grant: got %b start %b want %b start 1",
               bus.req_grant, bus.uart_tx_start, N'(1) << e);
    end
    @(negedge clk);
    ready_man = 1'b0;
    repeat (3) @(negedge clk);
    ready_man = 1'b1;
    wait_ack(5, ok);
    checks++;
    if (bus.req_ack !== N'(1) << e) begin
      errs++; $display("FAIL nr_ack: got %b want %b", bus.req_ack, N'(1) << e);
    end
    valid = '0;
    rr_last = e;
    uart_auto = 1'b1;
  endtask

  task automatic test_random();
    int cur, acks, bad_hold, stray;
    bit active, tracking;
    logic [7:0] held;
    logic [N-1:0] oh;
    wait_idle();
    uart_auto = 1'b1;
    drop_dly = $urandom_range(1, 3);
    frame_len = $urandom_range(2, 12);
    active = 1'b0; tracking = 1'b0;
    acks = 0; bad_hold = 0; stray = 0; cur = 0; held = 8'h00;
    for (int c = 0; c < 3000 && acks < 12; c++) begin
      @(negedge clk);
      if (bus.uart_tx_start === 1'b1) begin
        cur = rr_pick(valid, rr_last);
        oh = N'(1) << cur;
        checks++;
        if (bus.req_grant !== oh) begin
          errs++; $display("FAIL rnd_grant: got %b want %b", bus.req_grant, oh);
        end
        checks++;
        if (bus.uart_tx_data !== db[cur]) begin
          errs++; $display("FAIL rnd_data: got %h want %h", bus.uart_tx_data, db[cur]);
        end
        held = db[cur];
        tracking = 1'b1;
        active = 1'b1;
        if ($urandom_range(0, 7) == 0) valid = valid & ~oh;
      end else if (tracking && bus.uart_tx_data !== held) begin
        bad_hold++;
      end
      if (bus.req_ack !== '0) begin
        if (!active) begin
          stray++;
        end else begin
          checks++;
          if (bus.req_ack !== N'(1) << cur) begin
            errs++; $display("FAIL rnd_ack: got %b want %b", bus.req_ack, N'(1) << cur);
          end
          valid = valid & ~(N'(1) << cur);
          rr_last = cur;
          active = 1'b0;
          acks++;
          drop_dly = $urandom_range(1, 3);
          frame_len = $urandom_range(2, 12);
        end
      end else if (!active) begin
        if ($urandom_range(0, 3) == 0) valid = valid | N'($urandom);
        if (valid == '0) valid = N'($urandom_range(1, 15));
      end
      foreach (db[i]) db[i] = 8'($urandom);
    end
    checks++;
    if (acks != 12) begin
      errs++; $display("FAIL rnd_frames: got %0d want 12", acks);
    end
    checks++;
    if (bad_hold != 0) begin
      errs++; $display("FAIL rnd_hold: got %0d unstable cycles want 0", bad_hold);
    end
    checks++;
    if (stray != 0) begin
      errs++; $display("FAIL rnd_stray_ack: got %0d want 0", stray);
    end
    valid = '0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad, stray;
    do_reset();
    uart_auto = 1'b1;
    drop_dly = 1;
    frame_len = 30;
    valid = '1;
    wait_start(20, ok);
    wait_ack(100, ok);
    rr_last = 0;
    wait_start(20, ok);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_grant !== '0 || bus.busy !== 1'b0 ||
        bus.uart_tx_data !== 8'h00 || bus.uart_tx_start !== 1'b0 ||
        bus.req_ack !== '0) begin
      errs++;
      $display("FAIL mid_reset_out: got g=%b b=%b d=%h s=%b a=%b want all 0",
               bus.req_grant, bus.busy, bus.uart_tx_data,
               bus.uart_tx_start, bus.req_ack);
    end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.req_ack !== '0 || bus.req_grant !== '0) bad++;
    end
    rst_n = 1'b1;
    rr_last = N - 1;
    stray = 0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.req_ack !== '0) stray++;
      if (bus.uart_tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (bad + stray != 0 || !ok) begin
      errs++;
      $display("FAIL mid_no_ack: got %0d acks, restart %0d want 0, 1", bad + stray, ok);
    end
    checks++;
    if (bus.req_grant !== N'(1) << rr_pick(valid, rr_last)) begin
      errs++;
      $display("FAIL mid_restart: got %b want %b",
               bus.req_grant, N'(1) << rr_pick(valid, rr_last));
    end
    wait_ack(100, ok);
    valid = '0;
    rr_last = 0;
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int e, n, acks;
    wait_idle();
    do_reset();
    ready_man = 1'b1;
    uart_auto = 1'b0;
    valid = 4'b0110;
    e = rr_pick(valid, rr_last);
    wait_start(10, ok);
    n = 0; acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n++;
      if (bus.req_ack !== '0) acks++;
      if (bus.err_timeout === 1'b1) break;
    end
    checks++;
    if (n != TO + 1 || acks != 0) begin
      errs++; $display("FAIL to_delay: got %0d cycles %0d acks want %0d, 0", n, acks, TO + 1);
    end
    checks++;
    if (bus.req_grant !== '0) begin
      errs++; $display("FAIL to_grant_clr: got %b want 0", bus.req_grant);
    end
    wait_start(5, ok);
    checks++;
    if (bus.req_grant !== N'(1) << rr_pick(valid, rr_last)) begin
      errs++;
      $display("FAIL to_retry: got %b want %b",
               bus.req_grant, N'(1) << rr_pick(valid, rr_last));
    end
    @(negedge clk);
    ready_man = 1'b0;
    repeat (2) @(negedge clk);
    ready_man = 1'b1;
    wait_ack(5, ok);
    checks++;
    if (bus.req_ack !== N'(1) << e || bus.err_timeout !== 1'b1) begin
      errs++;
      $display("FAIL to_ack_sticky: got %b err %b want %b err 1",
               bus.req_ack, bus.err_timeout, N'(1) << e);
    end
    valid = '0;
    rr_last = e;
    uart_auto = 1'b1;
  endtask
`endif

  initial begin
    foreach (db[i]) db[i] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_not_ready();
    test_random();
    test_reset_mid();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
